imem_stream_loader: RTL and testbench

- Boot-time producer for the CPU instruction memory. It replaces the bench-side $readmemb with in-hardware loading.
- Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them sequentially into Instruction_Memory starting at word 0.
- Holds the CPU in reset while loading, then releases it and asserts its start input.
- Sits between an external host link (UART/JTAG bridge) and the CPU's clk_i/rst_i/start_i inputs plus the imem write port.

---
 rtl/imem_loader_pkg.sv | 17 +
 rtl/byte_to_word_packer.sv | 29 ++
 rtl/imem_stream_loader.sv | 147 ++++++++++++++
 tb/tb_imem_stream_loader.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory stream loader.
// The CSUM state is only reachable when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  // Two header bytes carry the little-endian word count.
  localparam int unsigned HDR_BYTES = 2;

endpackage

// File: rtl/byte_to_word_packer.sv
// Assembles four accepted bytes, least-significant first, into a 32-bit word.
// word_valid_o is combinational on the fourth byte so the caller can register it.
module byte_to_word_packer (
  input  logic        clk_i,
  input  logic        clear_i,
  input  logic [7:0]  byte_i,
  input  logic        accept_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q;
  logic [23:0] asm_q;

  always_ff @(posedge clk_i) begin
    if (clear_i) begin
      cnt_q <= '0;
      asm_q <= '0;
    end else if (accept_i) begin
      cnt_q <= cnt_q + 2'd1;
      asm_q <= {byte_i, asm_q[23:8]};
    end
  end

  // Only the first three bytes are stored; the fourth is taken straight from the input.
  assign word_o       = {byte_i, asm_q};
  assign word_valid_o = accept_i & (cnt_q == 2'd3);

endmodule

// File: rtl/imem_stream_loader.sv
// Boot loader: byte stream -> sequential imem word writes, then releases the CPU.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_stream_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              reload_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              cpu_rst_o,
  output logic              start_o,
  output logic              done_o,
  output logic              error_o,
  output logic [CNT_W-1:0]  words_o
);

  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, hdr_n, words_q;
  logic             acc, last_word, csum_ok, released;
  logic             pk_clear, pk_accept, pk_valid;
  logic [31:0]      pk_word;

  assign acc       = s_valid_i & s_ready_o;
  assign hdr_n     = CNT_W'({s_data_i, count_q[7:0]});
  assign last_word = (words_q == count_q - CNT_W'(1));
  assign words_o   = words_q;

  assign pk_clear  = ~rst_i | reload_i;
  assign pk_accept = acc & (state_q == DATA);

  byte_to_word_packer u_packer (
    .clk_i        (clk_i),
    .clear_i      (pk_clear),
    .byte_i       (s_data_i),
    .accept_i     (pk_accept),
    .word_o       (pk_word),
    .word_valid_o (pk_valid)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i || reload_i) begin
      xor_q <= '0;
    end else if (acc && state_q != CSUM) begin
      xor_q <= xor_q ^ s_data_i;
    end
  end

  assign csum_ok = (s_data_i == xor_q);
`else
  assign csum_ok = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= HDR0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (reload_i) begin
      state_d = HDR0;
    end else if (acc) begin
      case (state_q)
        HDR0: state_d = HDR1;
        HDR1: begin
          if (hdr_n == '0) begin
            state_d = DONE;
          end else if ({1'b0, hdr_n} > DEPTH_C) begin
            state_d = ERR;
          end else begin
            state_d = DATA;
          end
        end
        DATA: begin
          if (pk_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end
        end
        CSUM:    state_d = csum_ok ? DONE : ERR;
        default: state_d = state_q;
      endcase
    end
  end

  // The final word's strobe coincides with entering DONE; holding the CPU in reset
  // through that strobe cycle guarantees the write lands before the first fetch.
  always_comb begin
    released  = (state_q == DONE) & ~wr_en_o;
    s_ready_o = rst_i & ~reload_i &
                ((state_q == HDR0) | (state_q == HDR1) |
                 (state_q == DATA) | (state_q == CSUM));
    start_o   = released;
    done_o    = released;
    cpu_rst_o = ~released;
    error_o   = (state_q == ERR);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
      words_q   <= '0;
      count_q   <= '0;
    end else begin
      wr_en_o <= 1'b0;
      if (reload_i) begin
        words_q <= '0;
      end else if (acc) begin
        if (state_q == HDR0) begin
          count_q[7:0] <= s_data_i;
        end
        if (state_q == HDR1) begin
          count_q <= hdr_n;
        end
        if (pk_valid) begin
          wr_en_o   <= 1'b1;
          wr_addr_o <= words_q[ADDR_W-1:0];
          wr_data_o <= pk_word;
          words_q   <= words_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_stream_loader.sv
// Directed bench for imem_stream_loader: cycle table plus multi-cycle load sequences.
module tb_imem_stream_loader;

  logic        clk = 1'b0;
  logic        rst, reload, s_valid;
  logic [7:0]  s_data;
  logic        s_ready_o, wr_en_o, cpu_rst_o, start_o, done_o, error_o;
  logic [7:0]  wr_addr_o;
  logic [31:0] wr_data_o;
  logic [15:0] words_o;

  always #5 clk = ~clk;

  imem_stream_loader #(.DEPTH(256), .ADDR_W(8), .CNT_W(16)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .reload_i  (reload),
    .s_valid_i (s_valid),
    .s_data_i  (s_data),
    .s_ready_o (s_ready_o),
    .wr_en_o   (wr_en_o),
    .wr_addr_o (wr_addr_o),
    .wr_data_o (wr_data_o),
    .cpu_rst_o (cpu_rst_o),
    .start_o   (start_o),
    .done_o    (done_o),
    .error_o   (error_o),
    .words_o   (words_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst, rel, val;
    logic [7:0]  d;
    logic [61:0] exp;
  } vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef logic [7:0] bq_t[$];

  vec_t tbl[$];
  wr_t  wlog[$];

  always @(negedge clk) begin
    if (wr_en_o === 1'b1) wlog.push_back('{wr_addr_o, wr_data_o});
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic rl, input logic v, input logic [7:0] d,
                              input logic rdy, input logic wen, input logic [7:0] a,
                              input logic [31:0] wd, input logic crst, input logic st,
                              input logic dn, input logic er, input logic [15:0] wds);
    vec_t t;
    t.rst = r; t.rel = rl; t.val = v; t.d = d;
    t.exp = {rdy, wen, a, wd, crst, st, dn, er, wds};
    return t;
  endfunction

  function automatic bq_t make_stream(input logic [31:0] w[$]);
    bq_t q;
    logic [7:0] x;
    logic [15:0] n;
    n = 16'(w.size());
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    foreach (w[i]) for (int unsigned k = 0; k < 4; k++) q.push_back(w[i][8*k +: 8]);
    x = '0;
    foreach (q[i]) x = x ^ q[i];
`ifdef IMEM_LOADER_CHECKSUM_EN
    q.push_back(x);
`endif
    return q;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; reload = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    wlog.delete();
  endtask

  task automatic send(input bq_t b, input bit rnd, input string name);
    int unsigned i = 0;
    int unsigned cyc = 0;
    int unsigned budget;
    bit ok = 1'b1;
    budget = (imem_loader_pkg::HDR_BYTES + b.size()) * 8 + 50;
    while (i < b.size()) begin
      @(negedge clk);
      s_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_data  = b[i];
      #1;
      if (s_valid && s_ready_o) i++;
      cyc++;
      if (cyc > budget) begin
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk({name, "_send"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_end(input string name);
    int unsigned n = 0;
    while (!(done_o === 1'b1 || error_o === 1'b1) && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_end"}, 64'(n < 30), 64'd1);
  endtask

  task automatic check_log(input string name, input logic [31:0] w[$]);
    chk({name, "_nwr"}, 64'(wlog.size()), 64'(w.size()));
    foreach (w[i]) begin
      if (i < wlog.size()) chk({name, "_wr"}, {24'd0, wlog[i].addr, wlog[i].data}, {24'd0, 8'(i), w[i]});
    end
  endtask

  logic [31:0] w4[$];
  logic [31:0] wbig[$];
  logic [61:0] act;

  initial begin
    rst = 1'b0; reload = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);

`ifndef IMEM_LOADER_CHECKSUM_EN
    //             rst rl val data  rdy wen addr  wdata         crst st dn er words
    tbl.push_back(mk(0, 0, 1, 8'hAA, 0, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h02, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h13, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h50, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 0, 8'hFF, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'hB3, 1, 1, 8'h00, 32'h00500013, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 0, 1, 8'h80, 1, 0, 8'h00, 32'h00500013, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 0, 1, 8'h20, 1, 0, 8'h00, 32'h00500013, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00500013, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 0, 1, 8'h55, 0, 1, 8'h01, 32'h002080B3, 1, 0, 0, 0, 16'd2));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h01, 32'h002080B3, 0, 1, 1, 0, 16'd2));
    tbl.push_back(mk(1, 1, 1, 8'h01, 0, 0, 8'h01, 32'h002080B3, 0, 1, 1, 0, 16'd2));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 0, 8'h01, 32'h002080B3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h01, 32'h002080B3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h78, 1, 0, 8'h01, 32'h002080B3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h56, 1, 0, 8'h01, 32'h002080B3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h34, 1, 0, 8'h01, 32'h002080B3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h12, 1, 0, 8'h01, 32'h002080B3, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h00, 32'h12345678, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h12345678, 0, 1, 1, 0, 16'd1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 32'h12345678, 0, 1, 1, 0, 16'd1));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 0, 0, 8'h00, 32'h00000000, 1, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h00000000, 1, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 32'h00000000, 1, 0, 0, 1, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h00000000, 0, 1, 1, 0, 16'd0));
    tbl.push_back(mk(1, 1, 0, 8'h00, 0, 0, 8'h00, 32'h00000000, 0, 1, 1, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'hAA, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'hBB, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(0, 0, 1, 8'hCC, 0, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h01, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h00, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h11, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h22, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h33, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 1, 8'h44, 1, 0, 8'h00, 32'h00000000, 1, 0, 0, 0, 16'd0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 1, 8'h00, 32'h44332211, 1, 0, 0, 0, 16'd1));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 32'h44332211, 0, 1, 1, 0, 16'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst = tbl[i].rst; reload = tbl[i].rel; s_valid = tbl[i].val; s_data = tbl[i].d;
      #1;
      act = {s_ready_o, wr_en_o, wr_addr_o, wr_data_o, cpu_rst_o, start_o, done_o, error_o, words_o};
      chk($sformatf("vec%0d", i), 64'(act), 64'(tbl[i].exp));
    end
`endif

    w4 = '{32'h00500013, 32'h002080B3, 32'hDEADBEEF, 32'h0000006F};

    do_reset();
    send(make_stream(w4), 1'b0, "b2b");
    wait_end("b2b");
    check_log("b2b", w4);
    chk("b2b_start", {62'd0, start_o, cpu_rst_o}, 64'b10);
    chk("b2b_words", 64'(words_o), 64'd4);

    do_reset();
    send(make_stream(w4), 1'b1, "rnd");
    wait_end("rnd");
    check_log("rnd", w4);
    chk("rnd_done", {62'd0, done_o, error_o}, 64'b10);
    chk("rnd_words", 64'(words_o), 64'd4);

    for (int unsigned i = 0; i < 256; i++) wbig.push_back(32'hA5000000 ^ (i * 32'h00010203));
    do_reset();
    send(make_stream(wbig), 1'b0, "full");
    wait_end("full");
    chk("full_nwr", 64'(wlog.size()), 64'd256);
    if (wlog.size() == 256) begin
      chk("full_first", {24'd0, wlog[0].addr, wlog[0].data}, {24'd0, 8'h00, wbig[0]});
      chk("full_last", {24'd0, wlog[255].addr, wlog[255].data}, {24'd0, 8'hFF, wbig[255]});
    end
    chk("full_words", 64'(words_o), 64'd256);
    chk("full_done", {62'd0, done_o, start_o}, 64'b11);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    send('{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h42}, 1'b0, "csum_ok");
    wait_end("csum_ok");
    chk("csum_ok_state", {61'd0, done_o, start_o, error_o}, 64'b110);
    chk("csum_ok_nwr", 64'(wlog.size()), 64'd1);

    do_reset();
    send('{8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43}, 1'b0, "csum_bad");
    wait_end("csum_bad");
    chk("csum_bad_state", {61'd0, error_o, start_o, cpu_rst_o}, 64'b101);
    chk("csum_bad_nwr", 64'(wlog.size()), 64'd1);
    if (wlog.size() == 1) chk("csum_bad_data", 64'(wlog[0].data), 64'h00500013);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
